// File: rtl/scan_select_sequencer_pkg.sv
// Shared types and slot-search helper for the scan select sequencer.
package scan_pkg;

  typedef logic [1:0] slot_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Returns {found, slot}: first enabled slot after cur in the given
  // direction, looking at the three other slots only.
  function automatic logic [2:0] next_slot(slot_t cur, logic dir, logic [3:0] mask);
    slot_t      cand;
    logic [2:0] res;
    res = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      cand = (dir == DIR_UP) ? slot_t'(cur + slot_t'(k)) : slot_t'(cur - slot_t'(k));
      if (mask[cand] && !res[2]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_select_sequencer_prescaler.sv
// Dwell-time prescaler: counts 0..PRESCALE-1 while enabled, pulses tc on
// the terminal count.
module scan_prescaler #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PS_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [PS_W-1:0] TC_VAL = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_cnt;

  assign tc = en && (r_cnt == TC_VAL);

  // Count while enabled, wrap at terminal count, clear on request.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tc ? '0 : r_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/scan_select_sequencer.sv
// Select generator for a 2-to-4 one-hot decoder: steps slots 0..3 up or
// down at a prescaled rate, skipping masked-off slots.
module scan_select_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PS_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       dir,
  input  logic [3:0] mask,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic       x1,
  output logic       x2,
  output logic       tick,
  output logic       wrap,
  output logic       active
);

  state_t     r_state;
  slot_t      r_slot;
  logic       r_tick;
  logic       r_wrap;
  logic       r_active;

  logic       w_run_cond;
  logic       w_ps_en;
  logic       w_ps_clr;
  logic       w_tc;
  logic [2:0] w_next;
  logic       w_found;
  slot_t      w_new;
  logic       w_wrap;

  assign w_run_cond = en && (mask != '0);
  // Prescaler only counts while already in RUN and still allowed to run,
  // so entering RUN always starts the dwell from zero.
  assign w_ps_en    = (r_state == ST_RUN) && w_run_cond;
  assign w_ps_clr   = load || !w_ps_en;

  assign w_next  = next_slot(r_slot, dir, mask);
  assign w_found = w_next[2];
  assign w_new   = w_next[1:0];
  assign w_wrap  = (dir == DIR_UP) ? (w_new < r_slot) : (w_new > r_slot);

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_ps_clr),
    .en    (w_ps_en),
    .tc    (w_tc)
  );

  // FSM, slot register and registered tick/wrap/active outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_slot   <= '0;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_run_cond ? ST_RUN : ST_IDLE;
      r_active <= w_run_cond;
      r_tick   <= 1'b0;
      r_wrap   <= 1'b0;
      if (load) begin
        r_slot <= load_val;
      end else if (w_tc && w_found) begin
        r_slot <= w_new;
        r_tick <= 1'b1;
        r_wrap <= w_wrap;
      end
    end
  end

  assign x1     = r_slot[1];
  assign x2     = r_slot[0];
  assign tick   = r_tick;
  assign wrap   = r_wrap;
  assign active = r_active;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Scoreboard bench for scan_select_sequencer against a slot-level model.
module tb_scan_select_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       dir;
  logic [3:0] mask;
  logic       load;
  logic [1:0] load_val;
  logic       x1;
  logic       x2;
  logic       tick;
  logic       wrap;
  logic       active;

  always #5 clk = ~clk;

  scan_select_sequencer #(
    .PRESCALE (P),
    .PS_W     (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .mask     (mask),
    .load     (load),
    .load_val (load_val),
    .x1       (x1),
    .x2       (x2),
    .tick     (tick),
    .wrap     (wrap),
    .active   (active)
  );

  typedef struct {
    int e_idx;
    int slot;
    bit tick;
    bit wrap;
    bit active;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  // model state: current slot, cycles spent in it while running, running flag
  int   m_slot = 0;
  int   m_dwell = 0;
  bit   m_run = 0;

  always @(posedge clk) edge_cnt++;

  function automatic int find_next(int cur, bit d, bit [3:0] m);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = d ? (cur - k + 4) % 4 : (cur + k) % 4;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  // Apply inputs for the coming edge, predict its outputs, wait past it.
  task automatic cyc(input bit r, input bit e, input bit d, input bit [3:0] m,
                     input bit l, input bit [1:0] lv);
    exp_t x;
    bit   go;
    int   nx;
    reset = r; en = e; dir = d; mask = m; load = l; load_val = lv;
    x.e_idx = edge_cnt + 1;
    x.tick  = 0;
    x.wrap  = 0;
    go = e && (m != 4'b0000);
    if (r) begin
      m_slot = 0; m_dwell = 0; m_run = 0;
      x.active = 0;
    end else begin
      x.active = go;
      if (l) begin
        m_slot = int'(lv);
        m_dwell = 0;
      end else if (m_run && go) begin
        if (m_dwell == P - 1) begin
          m_dwell = 0;
          nx = find_next(m_slot, d, m);
          if (nx >= 0) begin
            x.tick = 1;
            x.wrap = d ? (nx > m_slot) : (nx < m_slot);
            m_slot = nx;
          end
        end else begin
          m_dwell++;
        end
      end else begin
        m_dwell = 0;
      end
      m_run = go;
    end
    x.slot = m_slot;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents a slot/tick/wrap/active set.
  exp_t mx;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        mx = q.pop_front();
        tests++;
        if ({x1, x2} !== 2'(mx.slot) || tick !== mx.tick || wrap !== mx.wrap ||
            active !== mx.active || edge_cnt != mx.e_idx) begin
          fails++;
          $display("FAIL cycle%0d: got slot=%0d tick=%b wrap=%b active=%b, expected slot=%0d tick=%b wrap=%b active=%b (edge %0d)",
                   mx.e_idx, {x1, x2}, tick, wrap, active, mx.slot, mx.tick, mx.wrap, mx.active, edge_cnt);
        end
      end
    end
  end

  bit       found;
  bit       cd;
  bit [3:0] cm;

  initial begin
    // reset held two cycles with en=1
    cyc(1, 1, 0, 4'b1111, 0, 0);
    cyc(1, 1, 0, 4'b1111, 0, 0);
    // up count through all slots
    for (int i = 0; i < 22; i++) cyc(0, 1, 0, 4'b1111, 0, 0);
    // down with mask 1010 from slot 3
    cyc(0, 1, 1, 4'b1010, 1, 3);
    for (int i = 0; i < 16; i++) cyc(0, 1, 1, 4'b1010, 0, 0);
    // load coincident with terminal count
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_run && m_dwell == P - 1) found = 1;
      else cyc(0, 1, 0, 4'b1111, 0, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL tc_align: got no terminal count within 20 cycles, expected one");
    end
    cyc(0, 1, 0, 4'b1111, 1, 2);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 4'b1111, 0, 0);
    // only slot 2 enabled, then mask cleared
    cyc(0, 1, 0, 4'b0100, 1, 2);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 4'b0100, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 4'b0000, 0, 0);
    // reset mid-run at slot 3 with prescaler at 2
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_run && m_slot == 3 && m_dwell == 2) found = 1;
      else cyc(0, 1, 0, 4'b1111, 0, 0);
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_align: got no slot3/count2 point within 40 cycles, expected one");
    end
    cyc(1, 1, 0, 4'b1111, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0, 4'b1111, 0, 0);
    // randomized traffic
    cd = 0;
    cm = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) cm = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) cd = ~cd;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, cd, cm,
          $urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
